// File: rtl/classifier_pkg.sv
// Shared RGB332 field widths, color/coverage codes and FSM states for the frame classifier.
package classifier_pkg;

    localparam int unsigned R_W   = 3;
    localparam int unsigned G_W   = 3;
    localparam int unsigned B_W   = 2;
    localparam int unsigned CNT_W = 15;

    typedef enum logic [1:0] {
        COLOR_NONE = 2'b00,
        COLOR_RED  = 2'b01,
        COLOR_BLUE = 2'b10
    } color_e;

    typedef enum logic [1:0] {
        COV_NONE = 2'b00,
        COV_LOW  = 2'b01,
        COV_MID  = 2'b10,
        COV_HIGH = 2'b11
    } coverage_e;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACCUM     = 2'd1,
        DECIDE    = 2'd2,
        PUBLISH   = 2'd3
    } state_e;

endpackage

// File: rtl/rgb332_pixel_classify.sv
// Combinational red/blue decision for one RGB332 pixel.
module rgb332_pixel_classify
    import classifier_pkg::*;
(
    input  logic [7:0] pixel,
    output logic       is_red,
    output logic       is_blue
);

    logic [R_W-1:0] w_r;
    logic [G_W-1:0] w_g;
    logic [B_W-1:0] w_b;

    assign w_r = pixel[7:5];
    assign w_g = pixel[4:2];
    assign w_b = pixel[1:0];

    // B<=1 for red and B==3 for blue keep the two classes disjoint.
    assign is_red  = (w_r >= 3'd5) && (w_g <= 3'd2) && (w_b <= 2'd1);
    assign is_blue = (w_b == 2'd3) && (w_r <= 3'd2) && (w_g <= 3'd3);

endmodule

// File: rtl/color_frame_classifier.sv
// Per-frame dominant color classifier on an RGB332 read stream.
// Optional CLASSIFIER_HYSTERESIS_EN: publish only after two equal consecutive decisions.
module color_frame_classifier
    import classifier_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 176,
    parameter int unsigned SCREEN_HEIGHT = 144,
    parameter int unsigned THRESHOLD     = 2000
)(
    input  logic       CLK,
    input  logic       RESET_NEG,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [3:0] RESULT,
    output logic       RESULT_VALID
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    state_e           w_next;
    logic [9:0]       r_x_d;
    logic [9:0]       r_y_d;
    logic             r_vsync;
    logic [CNT_W-1:0] r_red_cnt;
    logic [CNT_W-1:0] r_blue_cnt;
    logic [3:0]       r_decision;
    logic [3:0]       r_result;
    logic             r_valid;
`ifdef CLASSIFIER_HYSTERESIS_EN
    logic [3:0]       r_prev;
`endif

    logic             w_frame_end;
    logic             w_in_frame;
    logic             w_is_red;
    logic             w_is_blue;
    logic [31:0]      w_red_ext;
    logic [31:0]      w_blue_ext;
    logic [31:0]      w_win;
    color_e           w_color;
    coverage_e        w_cov;

    rgb332_pixel_classify u_classify (
        .pixel   (PIXEL_IN),
        .is_red  (w_is_red),
        .is_blue (w_is_blue)
    );

    assign w_frame_end = r_vsync & ~VGA_VSYNC_NEG;
    assign w_in_frame  = ({22'b0, r_x_d} < SCREEN_WIDTH) && ({22'b0, r_y_d} < SCREEN_HEIGHT);
    assign w_red_ext   = {{(32-CNT_W){1'b0}}, r_red_cnt};
    assign w_blue_ext  = {{(32-CNT_W){1'b0}}, r_blue_cnt};

    always_comb begin
        w_color = COLOR_NONE;
        w_win   = '0;
        w_cov   = COV_NONE;
        if (w_red_ext >= THRESHOLD && w_red_ext > w_blue_ext) begin
            w_color = COLOR_RED;
            w_win   = w_red_ext;
        end else if (w_blue_ext >= THRESHOLD && w_blue_ext > w_red_ext) begin
            w_color = COLOR_BLUE;
            w_win   = w_blue_ext;
        end
        if (w_color != COLOR_NONE) begin
            if (w_win < 2 * THRESHOLD)      w_cov = COV_LOW;
            else if (w_win < 4 * THRESHOLD) w_cov = COV_MID;
            else                            w_cov = COV_HIGH;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_SYNC: if (w_frame_end) w_next = ACCUM;
            ACCUM:     if (w_frame_end) w_next = DECIDE;
            DECIDE:    w_next = PUBLISH;
            PUBLISH:   w_next = ACCUM;
            default:   w_next = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) r_state <= WAIT_SYNC;
        else            r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            r_x_d      <= '0;
            r_y_d      <= '0;
            r_vsync    <= 1'b1;
            r_red_cnt  <= '0;
            r_blue_cnt <= '0;
            r_decision <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
`ifdef CLASSIFIER_HYSTERESIS_EN
            r_prev     <= '0;
`endif
        end else begin
            r_x_d   <= VGA_PIXEL_X;
            r_y_d   <= VGA_PIXEL_Y;
            r_vsync <= VGA_VSYNC_NEG;
            r_valid <= 1'b0;
            case (r_state)
                WAIT_SYNC: begin
                    r_red_cnt  <= '0;
                    r_blue_cnt <= '0;
                end
                ACCUM: begin
                    if (!w_frame_end && w_in_frame) begin
                        if (w_is_red && r_red_cnt != CNT_MAX)
                            r_red_cnt <= r_red_cnt + 1'b1;
                        if (w_is_blue && r_blue_cnt != CNT_MAX)
                            r_blue_cnt <= r_blue_cnt + 1'b1;
                    end
                end
                DECIDE: r_decision <= {w_cov, w_color};
                PUBLISH: begin
                    r_red_cnt  <= '0;
                    r_blue_cnt <= '0;
`ifdef CLASSIFIER_HYSTERESIS_EN
                    if (r_decision == r_prev) begin
                        r_result <= r_decision;
                        r_valid  <= 1'b1;
                    end
                    r_prev <= r_decision;
`else
                    r_result <= r_decision;
                    r_valid  <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign RESULT       = r_result;
    assign RESULT_VALID = r_valid;

endmodule

// File: tb/tb_color_frame_classifier.sv
// Directed and randomized frames checked against a counting reference model.
module tb_color_frame_classifier;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int T  = 20;
    localparam int SW = W + 4;
    localparam int SH = H + 2;

    logic       CLK;
    logic       RESET_NEG;
    logic [7:0] PIXEL_IN;
    logic [9:0] VGA_PIXEL_X;
    logic [9:0] VGA_PIXEL_Y;
    logic       VGA_VSYNC_NEG;
    logic [3:0] RESULT;
    logic       RESULT_VALID;

    color_frame_classifier #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .THRESHOLD     (T)
    ) dut (
        .CLK           (CLK),
        .RESET_NEG     (RESET_NEG),
        .PIXEL_IN      (PIXEL_IN),
        .VGA_PIXEL_X   (VGA_PIXEL_X),
        .VGA_PIXEL_Y   (VGA_PIXEL_Y),
        .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
        .RESULT        (RESULT),
        .RESULT_VALID  (RESULT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] fb [0:SH-1][0:SW-1];
    logic [3:0] m_result;
    logic [3:0] m_prev;
    logic       m_armed;
    int         n_checks;
    int         n_fail;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit px_red(input logic [7:0] p);
        int r, g, b;
        r = int'(p) / 32; g = (int'(p) / 4) % 8; b = int'(p) % 4;
        return (r >= 5) && (g <= 2) && (b <= 1);
    endfunction

    function automatic bit px_blue(input logic [7:0] p);
        int r, g, b;
        r = int'(p) / 32; g = (int'(p) / 4) % 8; b = int'(p) % 4;
        return (b == 3) && (r <= 2) && (g <= 3);
    endfunction

    function automatic logic [3:0] decide(input int nr, input int nb);
        int color, w, cov;
        color = 0; w = 0;
        if (nr >= T && nr > nb)      begin color = 1; w = nr; end
        else if (nb >= T && nb > nr) begin color = 2; w = nb; end
        if (color == 0)      cov = 0;
        else if (w < 2 * T)  cov = 1;
        else if (w < 4 * T)  cov = 2;
        else                 cov = 3;
        return 4'(cov * 4 + color);
    endfunction

    task automatic count_model(output int nr, output int nb);
        nr = 0; nb = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (px_red(fb[y][x]))  nr++;
                if (px_blue(fb[y][x])) nb++;
            end
        if (nr > 32767) nr = 32767;
        if (nb > 32767) nb = 32767;
    endtask

    task automatic clear_fb();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) fb[y][x] = 8'h00;
    endtask

    task automatic put_pixels(input logic [7:0] p, input int n, input int start);
        for (int i = start; i < start + n; i++) fb[i / W][i % W] = p;
    endtask

    task automatic fill_random();
        int pr, pb, s;
        pr = $urandom_range(0, 60);
        pb = $urandom_range(0, 60);
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                s = $urandom_range(0, 99);
                if (s < pr)
                    fb[y][x] = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
                else if (s < pr + pb)
                    fb[y][x] = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'b11};
                else
                    fb[y][x] = 8'($urandom);
            end
    endtask

    task automatic mid_reset();
        RESET_NEG = 1'b0;
        #1;
        check4("midreset_result", RESULT, 4'b0000);
        check4("midreset_valid", {3'b0, RESULT_VALID}, 4'b0000);
        m_result = 4'b0000;
        m_prev   = 4'b0000;
        m_armed  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_NEG = 1'b1;
    endtask

    task automatic drive_frame(input int abort_at);
        logic [7:0] nxt;
        int idx;
        nxt = 8'h00;
        idx = 0;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                @(posedge CLK); #1;
                PIXEL_IN    = nxt;
                VGA_PIXEL_X = 10'(x);
                VGA_PIXEL_Y = 10'(y);
                nxt = fb[y][x];
                if (idx == abort_at) mid_reset();
                idx++;
            end
        @(posedge CLK); #1;
        PIXEL_IN    = nxt;
        VGA_PIXEL_X = 10'd1023;
        VGA_PIXEL_Y = 10'd1023;
        @(posedge CLK); #1;
        PIXEL_IN = 8'h00;
    endtask

    task automatic frame_end(input string tag);
        int nr, nb, nvalid;
        logic exp_valid;
        logic [3:0] dec, got;
        @(negedge CLK);
        check4({tag, "_hold"}, RESULT, m_result);
        count_model(nr, nb);
        exp_valid = 1'b0;
        if (m_armed) begin
            dec = decide(nr, nb);
`ifdef CLASSIFIER_HYSTERESIS_EN
            if (dec == m_prev) begin
                exp_valid = 1'b1;
                m_result  = dec;
            end
            m_prev = dec;
`else
            exp_valid = 1'b1;
            m_result  = dec;
`endif
        end
        m_armed = 1'b1;
        @(posedge CLK); #1;
        VGA_VSYNC_NEG = 1'b0;
        nvalid = 0;
        got = RESULT;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (RESULT_VALID === 1'b1) begin
                nvalid++;
                got = RESULT;
            end
        end
        @(posedge CLK); #1;
        VGA_VSYNC_NEG = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_int({tag, "_valid_pulses"}, nvalid, exp_valid ? 1 : 0);
        check4({tag, "_result"}, RESULT, m_result);
        if (exp_valid) check4({tag, "_published"}, got, m_result);
    endtask

    task automatic run_frame(input string tag);
        drive_frame(-1);
        frame_end(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_result = 4'b0000;
        m_prev   = 4'b0000;
        m_armed  = 1'b0;
        RESET_NEG     = 1'b0;
        PIXEL_IN      = 8'h00;
        VGA_PIXEL_X   = 10'd1023;
        VGA_PIXEL_Y   = 10'd1023;
        VGA_VSYNC_NEG = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check4("reset_result", RESULT, 4'b0000);
        check4("reset_valid", {3'b0, RESULT_VALID}, 4'b0000);
        @(posedge CLK); #1;
        RESET_NEG = 1'b1;

        // Partial frame before the first edge only arms the classifier.
        clear_fb(); put_pixels(8'hE0, W * H, 0);
        run_frame("arm");

        clear_fb(); put_pixels(8'hE0, W * H, 0);
        run_frame("full_red");
        check4("full_red_code", RESULT, 4'b1101);

        clear_fb(); put_pixels(8'h03, T / 2, 0);
        run_frame("few_blue");

        clear_fb(); put_pixels(8'hE0, 30, 0); put_pixels(8'h03, 30, 30);
        run_frame("tie");

        clear_fb();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                if (x >= W || y >= H) fb[y][x] = 8'hE0;
        run_frame("out_of_range");
        check4("out_of_range_code", RESULT, 4'b0000);

        clear_fb(); put_pixels(8'hE0, T - 1, 0);     run_frame("red_T_minus_1");
        clear_fb(); put_pixels(8'hE0, T, 0);         run_frame("red_T");
        clear_fb(); put_pixels(8'hA0, 2 * T - 1, 0); run_frame("red_2T_minus_1");
        clear_fb(); put_pixels(8'hE0, 2 * T, 0);     run_frame("red_2T");
        clear_fb(); put_pixels(8'hE0, 4 * T, 0);     run_frame("red_4T");
        clear_fb(); put_pixels(8'h4F, 4 * T - 1, 0); run_frame("blue_4T_minus_1");
        clear_fb(); put_pixels(8'h03, T, 0); put_pixels(8'hE0, T - 1, T);
        run_frame("blue_over_red");

        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_frame($sformatf("random%0d", k));
        end

        clear_fb(); put_pixels(8'hE0, W * H, 0);
        run_frame("pre_reset_red");
        clear_fb(); put_pixels(8'hE0, W * H, 0);
        drive_frame(100);
        frame_end("after_reset_first_edge");
        clear_fb(); put_pixels(8'hE0, W * H, 0);
        run_frame("after_reset_red");

        clear_fb(); put_pixels(8'hE0, W * H, 0);   run_frame("hyst_red");
        clear_fb(); put_pixels(8'h03, 5 * T / 2, 0); run_frame("hyst_blue1");
        clear_fb(); put_pixels(8'h03, 5 * T / 2, 0); run_frame("hyst_blue2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
